// File: rtl/tl_demux_chk.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tl_demux_chk
// Description : Protocol monitor for tl_demux_route. It tracks upstream stalls
//               and raises sticky flags for hold violations and bad selects.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tl_demux_chk #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              ready_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sel_ok_i,
  output logic              oob_err_o,
  output logic              proto_err_o
);

  logic              r_stall;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_data;
  logic              r_oob;
  logic              r_proto;
  logic              w_stall_now;
  logic              w_hold_broken;

  assign w_stall_now   = valid_i && !ready_i;
  assign w_hold_broken = !valid_i || (sel_i != r_sel) || (data_i != r_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= 1'b0;
      r_sel   <= '0;
      r_data  <= '0;
      r_oob   <= 1'b0;
      r_proto <= 1'b0;
    end else begin
      r_stall <= w_stall_now;
      if (w_stall_now) begin
        r_sel  <= sel_i;
        r_data <= data_i;
      end
      // A stalled beat must be presented unchanged until it is accepted.
      if (r_stall && w_hold_broken) begin
        r_proto <= 1'b1;
      end
      if (valid_i && !sel_ok_i) begin
        r_oob <= 1'b1;
      end
    end
  end

  assign oob_err_o   = r_oob;
  assign proto_err_o = r_proto;

endmodule
`default_nettype wire

// File: rtl/tl_demux_route.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tl_demux_route
// Description : Zero-latency 1-to-N valid/ready demultiplexer with a clocked
//               protocol monitor on the upstream side.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tl_demux_route #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [SEL_W-1:0]    sel_i,
  output logic [N-1:0]        valid_o,
  input  logic [N-1:0]        ready_i,
  output logic [N*DATA_W-1:0] data_o,
  output logic                oob_err_o,
  output logic                proto_err_o
);

  logic [N-1:0] w_hit;
  logic         w_sel_ok;
  logic         w_ready;

  // Decode is independent of ready_i, so valid_o never loops back from ready.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < N; k++) begin
      w_hit[k] = (sel_i == SEL_W'(k));
    end
  end

  assign w_sel_ok = |w_hit;
  assign valid_o  = valid_i ? w_hit : '0;

  // An out-of-range select is acknowledged so the beat drains instead of hanging.
  always_comb begin
    w_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (w_hit[k]) begin
        w_ready = ready_i[k];
      end
    end
  end

  assign ready_o = w_ready;

  for (genvar k = 0; k < N; k++) begin : g_port
    assign data_o[k*DATA_W +: DATA_W] = data_i;
  end

  tl_demux_chk #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .ready_i     (w_ready),
    .sel_i       (sel_i),
    .data_i      (data_i),
    .sel_ok_i    (w_sel_ok),
    .oob_err_o   (oob_err_o),
    .proto_err_o (proto_err_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_tl_demux_route.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_tl_demux_route
// Description : Directed self-checking bench for tl_demux_route (N=4 and N=3).
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_tl_demux_route;

  logic        clk;
  logic        rst_n;

  logic        valid;
  logic [7:0]  data;
  logic [1:0]  sel;
  logic [3:0]  rdy;
  logic [3:0]  valid_o4;
  logic        ready_o4;
  logic [31:0] data_o4;
  logic        oob4;
  logic        proto4;

  logic        valid3;
  logic [7:0]  data3;
  logic [1:0]  sel3;
  logic [2:0]  rdy3;
  logic [2:0]  valid_o3;
  logic        ready_o3;
  logic [23:0] data_o3;
  logic        oob3;
  logic        proto3;

  int vectors;
  int miscompares;

  tl_demux_route #(.N(4), .DATA_W(8), .SEL_W(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .ready_o(ready_o4),
    .data_i(data), .sel_i(sel), .valid_o(valid_o4), .ready_i(rdy),
    .data_o(data_o4), .oob_err_o(oob4), .proto_err_o(proto4)
  );

  tl_demux_route #(.N(3), .DATA_W(8), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid3), .ready_o(ready_o3),
    .data_i(data3), .sel_i(sel3), .valid_o(valid_o3), .ready_i(rdy3),
    .data_o(data_o3), .oob_err_o(oob3), .proto_err_o(proto3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; registered outputs are read 1ns after the rising edge.
  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    valid = 1'b0; data = 8'h00; sel = 2'd0; rdy = 4'b0000;
    valid3 = 1'b0; data3 = 8'h00; sel3 = 2'd0; rdy3 = 3'b000;

    after_pos();
    chk("reset_oob4", 32'(oob4), 32'd0);
    chk("reset_proto4", 32'(proto4), 32'd0);
    chk("reset_oob3", 32'(oob3), 32'd0);
    // Routing is live even while reset is held.
    valid = 1'b1; sel = 2'd1; rdy = 4'b0010; #1;
    chk("reset_comb_valid", 32'(valid_o4), 32'h2);
    chk("reset_comb_ready", 32'(ready_o4), 32'd1);
    at_neg();
    rst_n = 1'b1;
    valid = 1'b0;

    // Port 0 route
    at_neg();
    valid = 1'b1; data = 8'hA0; sel = 2'd0; rdy = 4'b0001; #1;
    chk("p0_valid", 32'(valid_o4), 32'h1);
    chk("p0_data", 32'(data_o4[7:0]), 32'hA0);
    chk("p0_ready", 32'(ready_o4), 32'd1);
    after_pos();
    chk("p0_proto", 32'(proto4), 32'd0);
    chk("p0_oob", 32'(oob4), 32'd0);

    // Port 2 route, changing sel/data right after a completed transfer
    at_neg();
    data = 8'hC2; sel = 2'd2; rdy = 4'b0100; #1;
    chk("p2_valid", 32'(valid_o4), 32'h4);
    chk("p2_data", 32'(data_o4[23:16]), 32'hC2);
    chk("p2_repl", 32'(data_o4), 32'hC2C2C2C2);
    chk("p2_ready", 32'(ready_o4), 32'd1);
    after_pos();
    chk("p2_proto", 32'(proto4), 32'd0);

    // Backpressure, then accept with the beat held
    at_neg();
    data = 8'hB1; sel = 2'd1; rdy = 4'b0000; #1;
    chk("bp_valid", 32'(valid_o4), 32'h2);
    chk("bp_ready", 32'(ready_o4), 32'd0);
    at_neg();
    rdy = 4'b0010; #1;
    chk("bp_ready_now", 32'(ready_o4), 32'd1);
    after_pos();
    chk("bp_proto", 32'(proto4), 32'd0);

    // Ready from a port other than the selected one does not count
    at_neg();
    data = 8'hB2; rdy = 4'b1101; #1;
    chk("wp_ready", 32'(ready_o4), 32'd0);
    chk("wp_valid", 32'(valid_o4), 32'h2);
    at_neg();
    rdy = 4'b0010;
    after_pos();
    chk("wp_proto", 32'(proto4), 32'd0);

    // Stall on port 3, then change the payload
    at_neg();
    data = 8'h33; sel = 2'd3; rdy = 4'b0000; #1;
    chk("sv_valid", 32'(valid_o4), 32'h8);
    chk("sv_ready", 32'(ready_o4), 32'd0);
    after_pos();
    chk("sv_proto_pre", 32'(proto4), 32'd0);
    at_neg();
    data = 8'h34;
    after_pos();
    chk("sv_proto_set", 32'(proto4), 32'd1);
    after_pos();
    chk("sv_proto_sticky", 32'(proto4), 32'd1);

    // Reset in the middle of the stall
    at_neg();
    rst_n = 1'b0; #1;
    chk("rst_proto", 32'(proto4), 32'd0);
    chk("rst_oob", 32'(oob4), 32'd0);
    data = 8'h55;
    at_neg();
    rst_n = 1'b1; data = 8'h66;
    after_pos();
    chk("rst_release_proto", 32'(proto4), 32'd0);
    at_neg();
    rdy = 4'b1000;
    after_pos();
    chk("rst_drain_proto", 32'(proto4), 32'd0);

    // Dropping valid during a stall
    at_neg();
    data = 8'h77; sel = 2'd0; rdy = 4'b0000;
    at_neg();
    valid = 1'b0;
    after_pos();
    chk("vd_proto", 32'(proto4), 32'd1);
    chk("vd_oob4", 32'(oob4), 32'd0);

    // N=3 in-range select
    at_neg();
    valid3 = 1'b1; sel3 = 2'd2; data3 = 8'h5A; rdy3 = 3'b100; #1;
    chk("n3_valid", 32'(valid_o3), 32'h4);
    chk("n3_ready", 32'(ready_o3), 32'd1);
    chk("n3_data", 32'(data_o3), 32'h5A5A5A);
    after_pos();
    chk("n3_oob_clean", 32'(oob3), 32'd0);

    // N=3 out-of-range select drains and flags
    at_neg();
    sel3 = 2'd3; rdy3 = 3'b000; #1;
    chk("oob_valid", 32'(valid_o3), 32'h0);
    chk("oob_ready", 32'(ready_o3), 32'd1);
    chk("oob_pre", 32'(oob3), 32'd0);
    after_pos();
    chk("oob_set", 32'(oob3), 32'd1);
    chk("oob_proto", 32'(proto3), 32'd0);
    at_neg();
    valid3 = 1'b0;
    after_pos();
    chk("oob_sticky", 32'(oob3), 32'd1);
    at_neg();
    rst_n = 1'b0; #1;
    chk("oob_rst", 32'(oob3), 32'd0);
    at_neg();
    rst_n = 1'b1;
    after_pos();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tl_demux_route.md
Name: tl_demux_route

Overview:
- 1-to-N valid/ready demultiplexer for the TileLink crossbar.
- Routes one upstream beat to the downstream port chosen by sel_i and returns that port's ready upstream.
- The routing path is purely combinational, with zero cycles of latency.
- A clocked protocol monitor flags out-of-range selects and handshake violations.

Parameters:
- N, 4, number of downstream ports (at least 2).
- DATA_W, 8, payload width in bits.
- SEL_W, 2, select width; must satisfy 2^SEL_W >= N.

Ports:
- clk  input  1  clock; used only by the monitor.
- rst_n  input  1  reset: asynchronous, active-low, on clock clk.
- valid_i  input  1  upstream valid.
- ready_o  output  1  upstream ready.
- data_i  input  DATA_W  upstream payload.
- sel_i  input  SEL_W  destination port index.
- valid_o  output  N  per-port valid; bit k belongs to port k.
- ready_i  input  N  per-port ready.
- data_o  output  N*DATA_W  per-port payload; port k occupies data_o[k*DATA_W +: DATA_W].
- oob_err_o  output  1  sticky flag: a beat was issued with an out-of-range select.
- proto_err_o  output  1  sticky flag: upstream broke the hold rules during a stall.

Behaviour:
- Combinational path, no registers:
  - valid_o[k] = valid_i && (sel_i == k).
  - ready_o = ready_i[sel_i] when sel_i < N.
  - data_o: data_i is replicated onto every port slice regardless of sel_i. Consumers qualify the payload with valid_o.
  - A change on ready_i reaches ready_o in the same cycle.
  - No port's valid depends on its own ready, so there is no combinational loop from ready_i to valid_o.
- Out-of-range select (sel_i >= N, possible when N < 2^SEL_W):
  - valid_o is all zeros.
  - ready_o = 1, so the beat is discarded and the upstream cannot deadlock.
- Transfer rule: a transfer occurs on a clk edge where valid_i && ready_o.
- Monitor, clocked on clk, async reset:
  - stall_q is set on an edge where valid_i && !ready_o, and cleared otherwise.
  - On an edge where stall_q = 1, proto_err_o is set if any of these hold: valid_i == 0, sel_i differs from its captured value, or data_i differs from its captured value.
  - sel and data are captured on every stalled edge.
  - oob_err_o is set on any edge where valid_i && sel_i >= N.
  - Both error flags are sticky until reset.
  - The monitor never alters the routing outputs.
- Reset values:
  - stall_q = 0, oob_err_o = 0, proto_err_o = 0.
  - The combinational outputs follow their inputs even while in reset.
  - Asserting reset in the middle of a stall clears stall_q, and no error is raised on the edge after reset releases.
- Simultaneous events: a beat with valid_i and ready_o both high in the same cycle completes and raises no error. Changing sel_i or data_i on the following cycle is legal.

Decomposition:
- No shared package is needed. The parameters are local, and the error bit positions, if ever aggregated, belong in the crossbar's tl_xbar_pkg.
- One natural sub-module: tl_demux_chk, which holds stall_q, the captured sel/data, and both sticky flags.
- The top-level module holds the combinational routing only.

Test Plan:
- Port 0 route: valid_i=1, data_i=8'hA0, sel_i=0, ready_i=4'b0001 -> valid_o=4'b0001, data_o[7:0]=8'hA0, ready_o=1 in the same cycle; no error flags.
- Port 2 route: valid_i=1, data_i=8'hC2, sel_i=2, ready_i=4'b0100 -> valid_o=4'b0100, data_o[23:16]=8'hC2, ready_o=1.
- Backpressure: valid_i=1, data_i=8'hB1, sel_i=1, ready_i=0 -> valid_o[1]=1, ready_o=0. Next cycle set ready_i=4'b0010 with valid/sel/data held -> ready_o=1 immediately, proto_err_o stays 0.
- Wrong-port ready: sel_i=1, ready_i=4'b1101 -> ready_o=0, valid_o=4'b0010.
- Stall violation: stall on port 3 with ready_i=0, then change data_i on the next cycle -> proto_err_o=1 after that edge and stays 1. Assert rst_n=0 -> both error flags return to 0.
- Out-of-range select (N=3, SEL_W=2): valid_i=1, sel_i=3 -> valid_o=3'b000, ready_o=1, oob_err_o=1 after the edge.
